// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int MODE_ADD = 0;
    localparam int MODE_SUB = 1;

    // Bit-counter width: at least one bit even for a single-bit datapath.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/serial_addsub_fv_fa_cell.sv
// Registered 1-bit full adder: combinational sum bit, carry kept in a flop.
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_load_c,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    logic r_c;

    // Carry flop: seeded with carry-in on load, then ripples one bit per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c <= 1'b0;
        end else if (i_load) begin
            r_c <= i_load_c;
        end else if (i_en) begin
            r_c <= (i_a & i_b) | (i_a & r_c) | (i_b & r_c);
        end else begin
            r_c <= r_c;
        end
    end

    assign o_s = i_a ^ i_b ^ r_c;
    assign o_c = r_c;

endmodule

// File: rtl/serial_addsub_fv.sv
// Bit-serial add/subtract, LSB first, with valid/ready on both sides.
// Holds the FSM, operand/sum shift registers and the formal property set.
module serial_addsub_fv
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MODE        = 0,
    parameter int FORMAL_LIVE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_eff;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_s;
    logic             w_c;

    // Subtraction is a + ~b + cin, so only B needs conditioning at capture.
    assign w_b_eff  = (MODE == MODE_SUB) ? ~b : b;
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_shift  = (r_state == SHIFT);
    assign w_last   = (r_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = in_valid ? SHIFT : IDLE;
            SHIFT:   w_state_next = w_last ? DONE : SHIFT;
            DONE:    w_state_next = out_ready ? IDLE : DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake flags decoded purely from the state flop.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    always_comb begin
        w_sum_next            = r_sum >> 1'b1;
        w_sum_next[WIDTH-1]   = w_s;
    end

    // Operand, sum and bit-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= w_b_eff;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1'b1;
                    r_b   <= r_b >> 1'b1;
                    r_sum <= w_sum_next;
                    r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    serial_fa_cell u_fa (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_load_c (cin),
        .i_en     (w_shift),
        .i_a      (r_a[0]),
        .i_b      (r_b[0]),
        .o_s      (w_s),
        .o_c      (w_c)
    );

    assign sum  = r_sum;
    assign cout = w_c;

`ifdef FORMAL
    logic             r_f_started = 1'b0;
    logic [WIDTH-1:0] r_f_a;
    logic [WIDTH-1:0] r_f_b;
    logic             r_f_cin;
    logic [WIDTH:0]   w_f_ref;

    always @(posedge clk) r_f_started <= 1'b1;

    always_comb begin
        if (!r_f_started) begin
            assume (rst);
        end else begin
            assume (!rst);
        end
    end

    // Shadow copy of the accepted operands for the reference result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_a   <= '0;
            r_f_b   <= '0;
            r_f_cin <= 1'b0;
        end else if (w_accept) begin
            r_f_a   <= a;
            r_f_b   <= w_b_eff;
            r_f_cin <= cin;
        end else begin
            r_f_cin <= r_f_cin;
        end
    end

    assign w_f_ref = {1'b0, r_f_a} + {1'b0, r_f_b} + {{WIDTH{1'b0}}, r_f_cin};

    a_in_hold: assume property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (in_valid && $stable(a) && $stable(b) && $stable(cin)));
    p_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(sum) && $stable(cout)));
    p_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
    p_cnt: assert property (@(posedge clk) disable iff (rst) (int'(r_cnt) < WIDTH));
    p_ref: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> ({cout, sum} == w_f_ref));
`endif

    if (FORMAL_LIVE != 0) begin : g_live
`ifdef FORMAL
        a_rdy_live: assume property (@(posedge clk) disable iff (rst)
            out_valid |-> s_eventually out_ready);
        p_live: assert property (@(posedge clk) disable iff (rst)
            (in_valid && in_ready) |-> s_eventually out_valid);
`endif
    end

endmodule

// File: tb/tb_serial_addsub_fv.sv
// Directed bench: add/sub at WIDTH 8, single-bit add, backpressure, throughput, mid-op reset.
module tb_serial_addsub_fv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_s = 8'd0;
    logic [7:0] b_s = 8'd0;
    logic       cin_s = 1'b0;
    logic       out_ready_s = 1'b0;
    logic [2:0] in_valid_s = 3'd0;

    logic [2:0] in_ready_w;
    logic [2:0] out_valid_w;
    logic [2:0] cout_w;
    logic [2:0] busy_w;
    logic [7:0] sum_add_w;
    logic [7:0] sum_sub_w;
    logic [0:0] sum_one_w;

    int         sel = 0;
    logic       obs_rdy;
    logic       obs_vld;
    logic       obs_cout;
    logic       obs_busy;
    logic [7:0] obs_sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_addsub_fv #(.WIDTH(8), .MODE(0), .FORMAL_LIVE(1)) u_add8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .a(a_s), .b(b_s), .cin(cin_s), .out_valid(out_valid_w[0]), .out_ready(out_ready_s),
        .sum(sum_add_w), .cout(cout_w[0]), .busy(busy_w[0])
    );

    serial_addsub_fv #(.WIDTH(8), .MODE(1), .FORMAL_LIVE(1)) u_sub8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .a(a_s), .b(b_s), .cin(cin_s), .out_valid(out_valid_w[1]), .out_ready(out_ready_s),
        .sum(sum_sub_w), .cout(cout_w[1]), .busy(busy_w[1])
    );

    serial_addsub_fv #(.WIDTH(1), .MODE(0), .FORMAL_LIVE(1)) u_add1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
        .a(a_s[0:0]), .b(b_s[0:0]), .cin(cin_s), .out_valid(out_valid_w[2]), .out_ready(out_ready_s),
        .sum(sum_one_w), .cout(cout_w[2]), .busy(busy_w[2])
    );

    always_comb begin
        obs_rdy  = 1'b0;
        obs_vld  = 1'b0;
        obs_cout = 1'b0;
        obs_busy = 1'b0;
        obs_sum  = 8'd0;
        case (sel)
            0: begin
                obs_rdy = in_ready_w[0]; obs_vld = out_valid_w[0];
                obs_cout = cout_w[0]; obs_busy = busy_w[0]; obs_sum = sum_add_w;
            end
            1: begin
                obs_rdy = in_ready_w[1]; obs_vld = out_valid_w[1];
                obs_cout = cout_w[1]; obs_busy = busy_w[1]; obs_sum = sum_sub_w;
            end
            default: begin
                obs_rdy = in_ready_w[2]; obs_vld = out_valid_w[2];
                obs_cout = cout_w[2]; obs_busy = busy_w[2]; obs_sum = {7'd0, sum_one_w};
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (sel %0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    // Present operands for one edge, then count edges (accept edge included) until out_valid.
    task automatic send_and_wait(input int s, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input int exp_lat);
        int lat;
        sel = s;
        @(negedge clk);
        a_s = a; b_s = b; cin_s = c; in_valid_s[s] = 1'b1;
        #1;
        check_val("in_ready_before_accept", obs_rdy, 1);
        @(posedge clk);
        #1;
        in_valid_s[s] = 1'b0;
        check_val("busy_after_accept", obs_busy, 1);
        lat = 1;
        while (!obs_vld && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("latency", lat, exp_lat);
    endtask

    task automatic finish_txn(input logic [7:0] exp_sum, input logic exp_cout);
        check_val("sum", obs_sum, exp_sum);
        check_val("cout", obs_cout, exp_cout);
        check_val("in_ready_in_done", obs_rdy, 0);
        @(posedge clk);
        #1;
        check_val("in_ready_after_handshake", obs_rdy, 1);
        check_val("out_valid_after_handshake", obs_vld, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, obs_rdy, 1);
        check_val({tag, "_out_valid"}, obs_vld, 0);
        check_val({tag, "_sum"}, obs_sum, 0);
        check_val({tag, "_cout"}, obs_cout, 0);
        check_val({tag, "_busy"}, obs_busy, 0);
    endtask

    initial begin
        int rise_a;
        int rise_b;
        int edge_n;
        logic prev_vld;

        sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        out_ready_s = 1'b1;

        send_and_wait(0, 8'h5A, 8'h33, 1'b0, 9);
        finish_txn(8'h8D, 1'b0);
        send_and_wait(0, 8'hFF, 8'h01, 1'b1, 9);
        finish_txn(8'h01, 1'b1);

        send_and_wait(1, 8'h10, 8'h20, 1'b1, 9);
        finish_txn(8'hF0, 1'b0);
        send_and_wait(1, 8'h20, 8'h10, 1'b1, 9);
        finish_txn(8'h10, 1'b1);

        send_and_wait(2, 8'h01, 8'h01, 1'b1, 2);
        finish_txn(8'h01, 1'b1);

        // Backpressure: result must hold while new operands are waved at the unit.
        out_ready_s = 1'b0;
        send_and_wait(0, 8'h5A, 8'h33, 1'b0, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid_s[0] = 1'b1; a_s = 8'hAA; b_s = 8'h55; cin_s = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_out_valid", obs_vld, 1);
            check_val("bp_sum", obs_sum, 8'h8D);
            check_val("bp_cout", obs_cout, 0);
            check_val("bp_in_ready", obs_rdy, 0);
        end
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        out_ready_s = 1'b1;
        finish_txn(8'h8D, 1'b0);

        // Back-to-back with out_ready high: successive out_valid rises WIDTH+2 edges apart.
        sel = 0;
        @(negedge clk);
        a_s = 8'h01; b_s = 8'h02; cin_s = 1'b0; in_valid_s[0] = 1'b1;
        rise_a = -1; rise_b = -1; prev_vld = 1'b0; edge_n = 0;
        while (rise_b < 0 && edge_n < 60) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (obs_vld && !prev_vld) begin
                if (rise_a < 0) rise_a = edge_n;
                else rise_b = edge_n;
            end
            prev_vld = obs_vld;
        end
        check_val("throughput_gap", rise_b - rise_a, 10);
        check_val("throughput_sum", obs_sum, 8'h03);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        #1;
        check_val("throughput_idle", obs_rdy, 1);

        // Reset during the third SHIFT cycle, then a clean transaction.
        sel = 0;
        @(negedge clk);
        a_s = 8'h5A; b_s = 8'h33; cin_s = 1'b0; in_valid_s[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state("midop_reset");
        @(negedge clk);
        rst = 1'b0;
        send_and_wait(0, 8'h03, 8'h04, 1'b0, 9);
        finish_txn(8'h07, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
